// File: rtl/dsp_moving_average.sv
// dsp_moving_average: Wishbone classic master computing a 2^LOG2_TAPS-point moving average over SRAM sample blocks.
module dsp_moving_average #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int LOG2_TAPS = 2,
  parameter int LW        = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          start,
  input  logic [aw-1:0] src_addr,
  input  logic [aw-1:0] dst_addr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [aw-1:0] wb_m_adr_o,
  output logic [dw-1:0] wb_m_dat_o,
  output logic [3:0]    wb_m_sel_o,
  output logic          wb_m_we_o,
  output logic          wb_m_cyc_o,
  output logic          wb_m_stb_o,
  output logic [2:0]    wb_m_cti_o,
  output logic [1:0]    wb_m_bte_o,
  input  logic [dw-1:0] wb_m_dat_i,
  input  logic          wb_m_ack_i,
  input  logic          wb_m_err_i,
  input  logic          wb_m_rty_i
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int AW   = dw + LOG2_TAPS;
  typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_t;
  state_t state, nxt;
  logic [aw-1:0] src, dst;
  logic [LW-1:0] rem;
  logic [dw-1:0] s, res;
  logic [TAPS*dw-1:0] win;
  logic signed [AW-1:0] sum, sum_nxt;
  logic hold, err_q, act, ok;
  // hold masks the strobe for the single idle cycle that follows a retry
  assign act = (state == RD || state == WR) && !hold;
  assign ok  = act && wb_m_ack_i && !wb_m_err_i && !wb_m_rty_i;
  assign sum_nxt = sum + $signed({{LOG2_TAPS{s[dw-1]}}, s})
                       - $signed({{LOG2_TAPS{win[TAPS*dw-1]}}, win[TAPS*dw-1 -: dw]});
  assign wb_m_cyc_o = act;
  assign wb_m_stb_o = act;
  assign wb_m_we_o  = state == WR;
  assign wb_m_adr_o = state == WR ? dst : src;
  assign wb_m_dat_o = res;
  assign wb_m_sel_o = 4'hF;
  assign wb_m_cti_o = 3'b000;
  assign wb_m_bte_o = 2'b00;
  assign busy = state == RD || state == CALC || state == WR;
  assign done = state == DONE;
  assign err  = err_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (length == '0 ? DONE : RD) : IDLE;
      RD:      nxt = act && wb_m_err_i ? DONE : ok ? CALC : RD;
      CALC:    nxt = WR;
      WR:      nxt = act && wb_m_err_i ? DONE : ok ? (rem == LW'(1) ? DONE : RD) : WR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      rem   <= '0;
      s     <= '0;
      res   <= '0;
      win   <= '0;
      sum   <= '0;
      hold  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      hold  <= act && wb_m_rty_i && !wb_m_err_i;
      if (state == IDLE && start) begin
        err_q <= 1'b0;
        src   <= src_addr;
        dst   <= dst_addr;
        rem   <= length;
        win   <= '0;
        sum   <= '0;
      end
      if (act && wb_m_err_i) err_q <= 1'b1;
      if (state == RD && ok) s <= wb_m_dat_i;
      if (state == CALC) begin
        sum <= sum_nxt;
        win <= {win[(TAPS-1)*dw-1:0], s};
        res <= dw'(sum_nxt >>> LOG2_TAPS);
      end
      if (state == WR && ok) begin
        src <= src + aw'(4);
        dst <= dst + aw'(4);
        rem <= rem - LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dsp_moving_average.sv
// tb_dsp_moving_average: randomized jobs against a 1-wait-state Wishbone RAM model and a floor-average reference.
module tb_dsp_moving_average;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [15:0] length = 0;
  logic busy, done, err, we, cyc, stb, ack = 0, serr = 0, rty = 0;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  int total = 0, bad = 0;
  int nreads = 0, nwrites = 0, err_read_n = 0, rty_write_n = 0;
  int done_cnt = 0, cyc_cnt = 0;
  bit [31:0] mem [int];
  bit [31:0] samp [$];

  always #5 clk = ~clk;

  dsp_moving_average dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .busy(busy), .done(done), .err(err),
    .wb_m_adr_o(adr), .wb_m_dat_o(dat_o), .wb_m_sel_o(sel), .wb_m_we_o(we),
    .wb_m_cyc_o(cyc), .wb_m_stb_o(stb), .wb_m_cti_o(cti), .wb_m_bte_o(bte),
    .wb_m_dat_i(dat_i), .wb_m_ack_i(ack), .wb_m_err_i(serr), .wb_m_rty_i(rty)
  );

  assign dat_i = mem.exists(int'(adr)) ? mem[int'(adr)] : 32'h0;

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (cyc) cyc_cnt++;
    if (ack && we && cyc && stb) mem[int'(adr)] = dat_o;
    if (!rst_n) begin
      ack <= 0; serr <= 0; rty <= 0;
    end else if (cyc && stb && !ack && !serr && !rty) begin
      if (we) begin
        nwrites++;
        if (nwrites == rty_write_n) rty <= 1; else ack <= 1;
      end else begin
        nreads++;
        if (nreads == err_read_n) serr <= 1; else ack <= 1;
      end
    end else begin
      ack <= 0; serr <= 0; rty <= 0;
    end
  end

  function automatic int model(input int i);
    longint acc = 0;
    longint q;
    for (int j = i - 3; j <= i; j++)
      if (j >= 0) acc += longint'($signed(samp[j]));
    q = acc / 4;
    if (acc < 0 && acc % 4 != 0) q--;
    return int'(q);
  endfunction

  task automatic load(input logic [31:0] src);
    foreach (samp[i]) mem[int'(src + 32'(4 * i))] = samp[i];
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = 16'(n); start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (!done) begin bad++; $display("FAIL %s timeout waiting for done", nm); end
    @(negedge clk);
  endtask

  task automatic check_out(input logic [31:0] d, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      int got = int'(mem[int'(d + 32'(4 * i))]);
      total++;
      if (got !== model(i)) begin
        bad++; $display("FAIL %s[%0d] got=%0d exp=%0d", nm, i, got, model(i));
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1;
    total++;
    if ({busy, done, err, cyc, stb, we} !== 6'b0 || adr !== 0 || dat_o !== 0) begin
      bad++; $display("FAIL reset got=%b adr=%h dat=%h exp=0", {busy, done, err, cyc, stb, we}, adr, dat_o);
    end
    total++;
    if (sel !== 4'hF || cti !== 3'b000 || bte !== 2'b00) begin
      bad++; $display("FAIL constants sel=%h cti=%b bte=%b", sel, cti, bte);
    end
  endtask

  task automatic test_basic;
    int d0 = done_cnt;
    samp = '{4, 8, 12, 16, 20};
    load(32'h0);
    go(32'h0, 32'h1000, 5);
    wait_done("basic");
    check_out(32'h1000, 5, "basic");
    total++;
    if (done_cnt - d0 != 1 || err !== 0) begin
      bad++; $display("FAIL basic_done pulses=%0d err=%b exp 1/0", done_cnt - d0, err);
    end
    total++;
    if (mem[32'h100c] !== 32'd10) begin bad++; $display("FAIL basic_fixed got=%0d exp=10", mem[32'h100c]); end
  endtask

  task automatic test_negative;
    samp = '{-4, -4, -4, -4};
    load(32'h200);
    go(32'h200, 32'h1200, 4);
    wait_done("neg");
    check_out(32'h1200, 4, "neg");
    total++;
    if (int'(mem[32'h1204]) !== -2) begin bad++; $display("FAIL neg_shift got=%0d exp=-2", int'(mem[32'h1204])); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, 20);
      logic [31:0] s = 32'h4000 + 32'(k * 256);
      logic [31:0] d = 32'h8000 + 32'(k * 256);
      samp = {};
      for (int i = 0; i < n; i++) samp.push_back(k == 0 ? ($urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000) : $urandom);
      load(s);
      go(s, d, n);
      wait_done("rand");
      check_out(d, n, "rand");
    end
  endtask

  task automatic test_zero_length;
    int c0 = cyc_cnt, d0 = done_cnt;
    logic saw_busy = 0;
    @(negedge clk);
    length = 0; start = 1;
    @(negedge clk);
    start = 0;
    total++;
    if (done !== 1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
    repeat (4) begin saw_busy |= busy; @(negedge clk); end
    total++;
    if (cyc_cnt != c0 || saw_busy || done_cnt - d0 != 1) begin
      bad++; $display("FAIL zero_bus cyc=%0d busy=%b pulses=%0d exp 0/0/1", cyc_cnt - c0, saw_busy, done_cnt - d0);
    end
  endtask

  task automatic test_bus_error;
    int c0;
    samp = '{1, 2, 3, 4, 5};
    load(32'h500);
    nreads = 0; nwrites = 0; err_read_n = 3;
    go(32'h500, 32'h1500, 5);
    wait_done("err");
    c0 = cyc_cnt;
    repeat (5) @(negedge clk);
    total++;
    if (err !== 1 || nreads != 3 || nwrites != 2 || cyc_cnt != c0) begin
      bad++; $display("FAIL err_abort err=%b reads=%0d writes=%0d extra=%0d exp 1/3/2/0", err, nreads, nwrites, cyc_cnt - c0);
    end
    err_read_n = 0;
    go(32'h500, 32'h1600, 5);
    total++;
    if (err !== 0 || busy !== 1) begin bad++; $display("FAIL err_clear err=%b busy=%b exp 0/1", err, busy); end
    wait_done("err_restart");
    check_out(32'h1600, 5, "err_restart");
  endtask

  task automatic test_retry;
    logic [31:0] a, v;
    int n = 0;
    samp = '{100, -50, 7, 33, 9, 1000};
    load(32'h700);
    go(32'h700, 32'h1700, 6);
    wait_done("base");
    nwrites = 0; rty_write_n = 2;
    go(32'h700, 32'h1800, 6);
    while (!rty && n < 200) begin @(negedge clk); n++; end
    a = adr; v = dat_o;
    @(negedge clk);
    total++;
    if (stb !== 0 || cyc !== 0) begin bad++; $display("FAIL retry_gap stb=%b cyc=%b exp 0", stb, cyc); end
    @(negedge clk);
    total++;
    if (stb !== 1 || adr !== a || dat_o !== v || we !== 1 || a !== 32'h1804) begin
      bad++; $display("FAIL retry_reissue stb=%b adr=%h dat=%h exp 1 %h %h (adr 1804)", stb, adr, dat_o, a, v);
    end
    wait_done("retry");
    rty_write_n = 0;
    check_out(32'h1800, 6, "retry");
    for (int i = 0; i < 6; i++) begin
      total++;
      if (mem[32'h1800 + 4 * i] !== mem[32'h1700 + 4 * i]) begin
        bad++; $display("FAIL retry_image[%0d] got=%h exp=%h", i, mem[32'h1800 + 4 * i], mem[32'h1700 + 4 * i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    samp = '{3, 6, 9, 12, 15, 18, 21};
    load(32'h900);
    nwrites = 0;
    go(32'h900, 32'h1900, 7);
    repeat (5) @(negedge clk);
    start = 1; src_addr = 32'h0; dst_addr = 32'h1A00; length = 2;
    @(negedge clk);
    start = 0;
    wait_done("b2b");
    check_out(32'h1900, 7, "b2b");
    w0 = nwrites;
    total++;
    if (w0 != 7 || mem.exists(32'h1A00)) begin bad++; $display("FAIL b2b_ignore writes=%0d exp=7", w0); end
  endtask

  task automatic test_reset_mid_job;
    int d0, n = 0;
    samp = '{1, 1, 1};
    load(32'hB00);
    go(32'hB00, 32'h1B00, 3);
    while (!(we && cyc) && n < 200) begin @(negedge clk); n++; end
    d0 = done_cnt;
    rst_n = 0;
    @(negedge clk);
    total++;
    if (cyc !== 0 || stb !== 0 || busy !== 0) begin
      bad++; $display("FAIL midrst cyc=%b stb=%b busy=%b exp 0", cyc, stb, busy);
    end
    rst_n = 1;
    repeat (8) @(negedge clk);
    total++;
    if (done_cnt != d0 || busy !== 0) begin bad++; $display("FAIL midrst_done pulses=%0d busy=%b exp 0/0", done_cnt - d0, busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_random;
    test_zero_length;
    test_bus_error;
    test_retry;
    test_back_to_back;
    test_reset_mid_job;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
